up_down_seq_monitor: RTL and testbench

//  Passive checker on the q bus of an up/down counter; consumes the count the counter produces.

---
 rtl/up_down_seq_monitor.sv | 148 ++++++++++++++
 tb/tb_up_down_seq_monitor.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/up_down_seq_monitor.sv
// Passive monitor for the q bus of an up/down counter: infers direction, tracks the
// sequence and flags wraps, reversals, stalls and illegal jumps. Option: UDMON_STICKY_ERR_EN.
module up_down_seq_monitor #(
  parameter int WIDTH     = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [WIDTH-1:0]     q,
  output logic                 locked,
  output logic                 dir,
  output logic                 wrap,
  output logic                 rev,
  output logic                 stall,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACQ  = 2'd1,
    LOCK = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0]     ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]     MAX     = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]     ZERO    = {WIDTH{1'b0}};
  localparam logic [ERR_CNT_W-1:0] CNT_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       prev_q, prev_d;
  logic                   dir_q, dir_d;
  logic                   locked_q, locked_d;
  logic                   wrap_q, wrap_d;
  logic                   rev_q, rev_d;
  logic                   stall_q, stall_d;
  logic                   err_q, err_d;
  logic [ERR_CNT_W-1:0]   err_count_q, err_count_d;

  logic [WIDTH-1:0] prev_plus1, prev_minus1;
  logic             step_up, step_dn, same, wrap_step, illegal;

  assign prev_plus1  = prev_q + ONE;
  assign prev_minus1 = prev_q - ONE;
  assign step_up     = (q == prev_plus1);
  assign step_dn     = (q == prev_minus1);
  assign same        = (q == prev_q);
  // A legal step wraps only when it crosses the MAX/0 boundary in its own direction.
  assign wrap_step   = (step_up && (prev_q == MAX)) || (step_dn && (prev_q == ZERO));

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    dir_d       = dir_q;
    locked_d    = locked_q;
    wrap_d      = 1'b0;
    rev_d       = 1'b0;
    stall_d     = 1'b0;
    err_count_d = err_count_q;
    illegal     = 1'b0;

    if (en) begin
      prev_d = q;
      case (state_q)
        IDLE: begin
          state_d = ACQ;
        end
        ACQ: begin
          if (step_up) begin
            dir_d    = 1'b1;
            locked_d = 1'b1;
            state_d  = LOCK;
            wrap_d   = wrap_step;
          end else if (step_dn) begin
            dir_d    = 1'b0;
            locked_d = 1'b1;
            state_d  = LOCK;
            wrap_d   = wrap_step;
          end else if (same) begin
            stall_d = 1'b1;
          end
        end
        LOCK: begin
          if (dir_q ? step_up : step_dn) begin
            wrap_d = wrap_step;
          end else if (dir_q ? step_dn : step_up) begin
            rev_d  = 1'b1;
            dir_d  = ~dir_q;
            wrap_d = wrap_step;
          end else if (same) begin
            stall_d = 1'b1;
          end else begin
            illegal  = 1'b1;
            locked_d = 1'b0;
            state_d  = ACQ;
            if (err_count_q != CNT_MAX) begin
              err_count_d = err_count_q + CNT_ONE;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

`ifdef UDMON_STICKY_ERR_EN
    err_d = err_q | illegal;
`else
    err_d = illegal;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      prev_q      <= ZERO;
      dir_q       <= 1'b0;
      locked_q    <= 1'b0;
      wrap_q      <= 1'b0;
      rev_q       <= 1'b0;
      stall_q     <= 1'b0;
      err_q       <= 1'b0;
      err_count_q <= {ERR_CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      dir_q       <= dir_d;
      locked_q    <= locked_d;
      wrap_q      <= wrap_d;
      rev_q       <= rev_d;
      stall_q     <= stall_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
    end
  end

  assign locked    = locked_q;
  assign dir       = dir_q;
  assign wrap      = wrap_q;
  assign rev       = rev_q;
  assign stall     = stall_q;
  assign err       = err_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_up_down_seq_monitor.sv
// Scoreboard bench for up_down_seq_monitor: directed samples push expected outputs,
// a monitor pops and compares one entry per clock, 1 time unit after the rising edge.
module tb_up_down_seq_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [3:0] q   = 4'd0;

  logic       locked, dir, wrap, rev, stall, err;
  logic [7:0] err_count;
  logic       locked2, dir2, wrap2, rev2, stall2, err2;
  logic [1:0] err_count2;

  up_down_seq_monitor #(.WIDTH(4), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .q(q),
    .locked(locked), .dir(dir), .wrap(wrap), .rev(rev),
    .stall(stall), .err(err), .err_count(err_count)
  );

  up_down_seq_monitor #(.WIDTH(4), .ERR_CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .q(q),
    .locked(locked2), .dir(dir2), .wrap(wrap2), .rev(rev2),
    .stall(stall2), .err(err2), .err_count(err_count2)
  );

  always #5 clk = ~clk;

  typedef struct {
    int  id;
    bit  lk, dr, wr, rv, st, er, chk_dir;
    int  ec, ec2;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   step_id = 0;
  bit   sticky_exp = 1'b0;

  task automatic chk(input string name, input int id, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL step %0d %s: got %0d expected %0d", id, name, act, req);
    end
  endtask

  // Monitor: one scoreboard entry per clock edge following a stimulus.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("locked", e.id, int'(locked), int'(e.lk));
      if (e.chk_dir) chk("dir", e.id, int'(dir), int'(e.dr));
      chk("wrap", e.id, int'(wrap), int'(e.wr));
      chk("rev", e.id, int'(rev), int'(e.rv));
      chk("stall", e.id, int'(stall), int'(e.st));
      chk("err", e.id, int'(err), int'(e.er));
      chk("err_count", e.id, int'(err_count), e.ec);
      chk("err_count_w2", e.id, int'(err_count2), e.ec2);
      $display("[TB] step %0d q=%0d locked=%0b dir=%0b wrap=%0b rev=%0b stall=%0b err=%0b cnt=%0d cnt2=%0d",
               e.id, q, locked, dir, wrap, rev, stall, err, err_count, err_count2);
    end
  end

  // er is the per-transition illegal flag; the sticky build folds it into a held flag.
  task automatic step(input bit r, input bit e, input int qv,
                      input bit lk, input bit dr, input bit wr, input bit rv,
                      input bit st, input bit er, input int ec);
    exp_t x;
    @(negedge clk);
    rst = r;
    en  = e;
    q   = 4'(qv);
    step_id++;
`ifdef UDMON_STICKY_ERR_EN
    sticky_exp = r ? 1'b0 : (sticky_exp | er);
    x.er = sticky_exp;
`else
    x.er = er;
`endif
    x.id = step_id;
    x.lk = lk; x.dr = dr; x.wr = wr; x.rv = rv; x.st = st;
    x.chk_dir = lk | r;
    x.ec  = ec;
    x.ec2 = (ec > 3) ? 3 : ec;
    sb.push_back(x);
  endtask

  initial begin
    // Up-count lock with wrap 15 -> 0
    step(1,1, 0, 0,0,0,0,0,0,0);
    step(0,1,13, 0,0,0,0,0,0,0);
    step(0,1,14, 1,1,0,0,0,0,0);
    step(0,1,15, 1,1,0,0,0,0,0);
    step(0,1, 0, 1,1,1,0,0,0,0);
    step(0,1, 1, 1,1,0,0,0,0,0);
    // Reversal up -> down
    step(1,1, 3, 0,0,0,0,0,0,0);
    step(0,1, 5, 0,0,0,0,0,0,0);
    step(0,1, 6, 1,1,0,0,0,0,0);
    step(0,1, 7, 1,1,0,0,0,0,0);
    step(0,1, 6, 1,0,0,1,0,0,0);
    step(0,1, 5, 1,0,0,0,0,0,0);
    step(0,1, 4, 1,0,0,0,0,0,0);
    // Reverse back up, then skip 4 -> 6 and relock
    step(0,1, 3, 1,0,0,0,0,0,0);
    step(0,1, 4, 1,1,0,1,0,0,0);
    step(0,1, 6, 0,1,0,0,0,1,1);
    step(0,1, 7, 1,1,0,0,0,0,1);
    step(0,1, 8, 1,1,0,0,0,0,1);
    // Stall, then an ignored en=0 cycle
    step(0,1, 9, 1,1,0,0,0,0,1);
    step(0,1, 9, 1,1,0,0,1,0,1);
    step(0,0, 2, 1,1,0,0,0,0,1);
    step(0,1,10, 1,1,0,0,0,0,1);
    // Two more errors to reach 3, then reset mid-sequence and relock
    step(0,1,13, 0,1,0,0,0,1,2);
    step(0,1,14, 1,1,0,0,0,0,2);
    step(0,1, 0, 0,1,0,0,0,1,3);
    step(0,1, 1, 1,1,0,0,0,0,3);
    step(0,1, 2, 1,1,0,0,0,0,3);
    step(1,1, 3, 0,0,0,0,0,0,0);
    step(0,1, 2, 0,0,0,0,0,0,0);
    step(0,1, 3, 1,1,0,0,0,0,0);
    // Stall during acquisition, down-lock via 0 -> 15 wrap, rev+wrap together
    step(1,1, 0, 0,0,0,0,0,0,0);
    step(0,1, 7, 0,0,0,0,0,0,0);
    step(0,1, 7, 0,0,0,0,1,0,0);
    step(0,1, 0, 0,0,0,0,0,0,0);
    step(0,1,15, 1,0,1,0,0,0,0);
    step(0,1, 0, 1,1,1,1,0,0,0);
    // Five illegal jumps: 2-bit counter saturates at 3
    step(0,1, 5, 0,1,0,0,0,1,1);
    step(0,1, 6, 1,1,0,0,0,0,1);
    step(0,1, 9, 0,1,0,0,0,1,2);
    step(0,1,10, 1,1,0,0,0,0,2);
    step(0,1, 1, 0,1,0,0,0,1,3);
    step(0,1, 2, 1,1,0,0,0,0,3);
    step(0,1, 8, 0,1,0,0,0,1,4);
    step(0,1, 9, 1,1,0,0,0,0,4);
    step(0,1, 3, 0,1,0,0,0,1,5);
    step(0,0, 4, 0,1,0,0,0,0,5);
    step(1,0, 4, 0,0,0,0,0,0,0);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    #2;
    if (sb.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
